imem_loader: RTL

- Write-side counterpart to the instruction memory's read port: boots a program into instruction memory from a byte stream.
- Receives bytes over a valid/ready handshake, assembles them into 16-bit instruction words (high byte first), and issues one write per word at even byte addresses 0, 2, 4, ...
- The datapath uses `busy` to hold the pipeline in stall while loading, and `done` to release the PC.

---
 rtl/imem_loader_if.sv | 38 +++
 rtl/imem_loader.sv | 138 +++++++++++++
 2 files changed

// File: rtl/imem_loader_if.sv
// imem_loader_if: signal bundle between the instruction-memory boot loader
// and its surroundings (byte source, instruction-memory write port, and the
// stall/PC-release status seen by the datapath).
//
//   start     host -> loader   single-cycle load request
//   in_data   source -> loader incoming stream byte
//   in_valid  source -> loader in_data valid
//   in_ready  loader -> source byte accepted this cycle
//   wr_en     loader -> imem   write strobe, one cycle per word
//   wr_addr   loader -> imem   byte address of the word
//   wr_data   loader -> imem   instruction word {high byte, low byte}
//   busy      loader -> core   load in progress (pipeline stall)
//   done      loader -> core   last load completed (sticky)
//   error     loader -> core   header count too large (sticky)
//
// master: the loader itself. slave: everything it talks to.
interface imem_loader_if;
    logic        start;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic        wr_en;
    logic [15:0] wr_addr;
    logic [15:0] wr_data;
    logic        busy;
    logic        done;
    logic        error;

    modport master (
        input  start, in_data, in_valid,
        output in_ready, wr_en, wr_addr, wr_data, busy, done, error
    );

    modport slave (
        output start, in_data, in_valid,
        input  in_ready, wr_en, wr_addr, wr_data, busy, done, error
    );
endinterface

// File: rtl/imem_loader.sv
// imem_loader: boots a program into instruction memory from a byte stream.
// Stream format: 16-bit word count (high byte first), then that many 16-bit
// instruction words (high byte first). Each word is written at
// BASE_ADDR + 2*k. All outputs are registered.
//
// Ports:
//   clk   system clock, rising edge
//   rst   synchronous active-high reset
//   bus   imem_loader_if.master (start, byte stream, imem write, status)
//
// state   | meaning
// --------+--------------------------------------------------
// IDLE    | after reset, waiting for start
// LEN_HI  | waiting for high byte of word count
// LEN_LO  | waiting for low byte of word count, then validate
// DATA_HI | waiting for high byte of next instruction
// DATA_LO | waiting for low byte; registers the write
// WRITE   | one-cycle write strobe, advance word counter
// DONE    | load finished successfully, waiting for start
// ERROR   | count exceeded MAX_WORDS, waiting for start
module imem_loader #(
    parameter int          MAX_WORDS = 8,
    parameter logic [15:0] BASE_ADDR = 16'h0000
) (
    input  logic          clk,
    input  logic          rst,
    imem_loader_if.master bus
);

    localparam int CW = $clog2(MAX_WORDS + 1);

    typedef enum logic [2:0] {
        IDLE, LEN_HI, LEN_LO, DATA_HI, DATA_LO, WRITE, DONE, ERROR
    } state_t;

    state_t          state;
    logic [15:0]     len;
    logic [CW-1:0]   count;
    logic [7:0]      hi;

    logic            xfer;
    logic [15:0]     len_next;
    logic [15:0]     count_ext;
    logic [15:0]     count_inc;

    assign xfer      = bus.in_valid && bus.in_ready;
    // Full count as it will be once the low byte lands this cycle.
    assign len_next  = {len[15:8], bus.in_data};
    assign count_ext = 16'(count);
    assign count_inc = count_ext + 16'd1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            len          <= '0;
            count        <= '0;
            hi           <= '0;
            bus.in_ready <= 1'b0;
            bus.wr_en    <= 1'b0;
            bus.wr_addr  <= '0;
            bus.wr_data  <= '0;
            bus.busy     <= 1'b0;
            bus.done     <= 1'b0;
            bus.error    <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE, ERROR: begin
                    if (bus.start) begin
                        state        <= LEN_HI;
                        count        <= '0;
                        bus.done     <= 1'b0;
                        bus.error    <= 1'b0;
                        bus.busy     <= 1'b1;
                        bus.in_ready <= 1'b1;
                    end
                end
                LEN_HI: begin
                    if (xfer) begin
                        len[15:8] <= bus.in_data;
                        state     <= LEN_LO;
                    end
                end
                LEN_LO: begin
                    if (xfer) begin
                        len[7:0] <= bus.in_data;
                        if (len_next == 16'd0) begin
                            state        <= DONE;
                            bus.in_ready <= 1'b0;
                            bus.busy     <= 1'b0;
                            bus.done     <= 1'b1;
                        end else if (len_next > 16'(MAX_WORDS)) begin
                            state        <= ERROR;
                            bus.in_ready <= 1'b0;
                            bus.busy     <= 1'b0;
                            bus.error    <= 1'b1;
                        end else begin
                            state <= DATA_HI;
                        end
                    end
                end
                DATA_HI: begin
                    if (xfer) begin
                        hi    <= bus.in_data;
                        state <= DATA_LO;
                    end
                end
                DATA_LO: begin
                    if (xfer) begin
                        bus.wr_data  <= {hi, bus.in_data};
                        bus.wr_addr  <= BASE_ADDR + (count_ext << 1);
                        bus.wr_en    <= 1'b1;
                        bus.in_ready <= 1'b0;
                        state        <= WRITE;
                    end
                end
                WRITE: begin
                    bus.wr_en <= 1'b0;
                    count     <= count + CW'(1);
                    if (count_inc == len) begin
                        state    <= DONE;
                        bus.busy <= 1'b0;
                        bus.done <= 1'b1;
                    end else begin
                        state        <= DATA_HI;
                        bus.in_ready <= 1'b1;
                    end
                end
                default: begin
                    state        <= IDLE;
                    bus.in_ready <= 1'b0;
                    bus.wr_en    <= 1'b0;
                    bus.busy     <= 1'b0;
                end
            endcase
        end
    end

endmodule
